// File: rtl/fp_issue_queue_if.sv
// Dispatch, writeback-snoop, flush and issue signals of the FP issue queue.
// The queue uses the slave modport; the producer/consumer side uses master.
interface fp_issue_queue_if #(
    parameter int DEPTH = 8,
    parameter int MOP_W = 8,
    parameter int AW    = 32,
    parameter int RAW   = 5,
    parameter int DW    = 64
);
    logic                     InValid;
    logic                     InReady;
    logic [MOP_W-1:0]         InMicOp;
    logic [AW-1:0]            InInstAddr;
    logic                     InPredict;
    logic [31:0]              InJumpOffset;
    logic [RAW-1:0]           InRdAddr;
    logic [RAW-1:0]           InSrc1Addr;
    logic [RAW-1:0]           InSrc2Addr;
    logic                     InSrc1Rdy;
    logic                     InSrc2Rdy;
    logic [DW-1:0]            InSrc1Data;
    logic [DW-1:0]            InSrc2Data;
    logic                     WbValid;
    logic [RAW-1:0]           WbAddr;
    logic [DW-1:0]            WbData;
    logic                     Flush;
    logic                     IssValid;
    logic [MOP_W-1:0]         IssMicOp;
    logic [AW-1:0]            IssInstAddr;
    logic                     IssPredict;
    logic [31:0]              IssJumpOffset;
    logic [RAW-1:0]           IssRdAddr;
    logic [DW-1:0]            IssSrc1Data;
    logic [DW-1:0]            IssSrc2Data;
    logic [$clog2(DEPTH):0]   Count;

    modport slave (
        input  InValid, InMicOp, InInstAddr, InPredict, InJumpOffset, InRdAddr,
               InSrc1Addr, InSrc2Addr, InSrc1Rdy, InSrc2Rdy, InSrc1Data, InSrc2Data,
               WbValid, WbAddr, WbData, Flush,
        output InReady, IssValid, IssMicOp, IssInstAddr, IssPredict, IssJumpOffset,
               IssRdAddr, IssSrc1Data, IssSrc2Data, Count
    );

    modport master (
        output InValid, InMicOp, InInstAddr, InPredict, InJumpOffset, InRdAddr,
               InSrc1Addr, InSrc2Addr, InSrc1Rdy, InSrc2Rdy, InSrc1Data, InSrc2Data,
               WbValid, WbAddr, WbData, Flush,
        input  InReady, IssValid, IssMicOp, IssInstAddr, IssPredict, IssJumpOffset,
               IssRdAddr, IssSrc1Data, IssSrc2Data, Count
    );
endinterface

// File: rtl/fp_issue_queue.sv
// In-order FP issue queue: holds dispatched ops with operand data, snoops the
// FALU writeback bus for pending sources, and issues the head once it is ready.
module fp_issue_queue #(
    parameter int DEPTH = 8,
    parameter int MOP_W = 8,
    parameter int AW    = 32,
    parameter int RAW   = 5,
    parameter int DW    = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    fp_issue_queue_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] r_vld, r_s1r, r_s2r;
    logic [MOP_W-1:0] r_mop [DEPTH];
    logic [AW-1:0]    r_pc  [DEPTH];
    logic             r_pred[DEPTH];
    logic [31:0]      r_off [DEPTH];
    logic [RAW-1:0]   r_rd  [DEPTH];
    logic [RAW-1:0]   r_s1a [DEPTH];
    logic [RAW-1:0]   r_s2a [DEPTH];
    logic [DW-1:0]    r_s1d [DEPTH];
    logic [DW-1:0]    r_s2d [DEPTH];

    logic [PW-1:0]    r_head, r_tail;
    logic [CW-1:0]    r_cnt;

    logic             r_iss_vld;
    logic [MOP_W-1:0] r_iss_mop;
    logic [AW-1:0]    r_iss_pc;
    logic             r_iss_pred;
    logic [31:0]      r_iss_off;
    logic [RAW-1:0]   r_iss_rd;
    logic [DW-1:0]    r_iss_s1d, r_iss_s2d;

    logic             w_enq, w_iss, w_in1_rdy, w_in2_rdy;
    logic [DEPTH-1:0] w_wake1, w_wake2;

    assign bus.InReady = (r_cnt < CW'(DEPTH));
    assign w_enq       = bus.InValid & bus.InReady;
    // Head readiness uses registered bits only; a wakeup lands one cycle later.
    assign w_iss       = r_vld[r_head] & r_s1r[r_head] & r_s2r[r_head];
    assign w_in1_rdy   = bus.InSrc1Rdy | (bus.WbValid & (bus.WbAddr == bus.InSrc1Addr));
    assign w_in2_rdy   = bus.InSrc2Rdy | (bus.WbValid & (bus.WbAddr == bus.InSrc2Addr));

    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wake1[i] = r_vld[i] & ~r_s1r[i] & bus.WbValid & (r_s1a[i] == bus.WbAddr);
            w_wake2[i] = r_vld[i] & ~r_s2r[i] & bus.WbValid & (r_s2a[i] == bus.WbAddr);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld      <= '0;
            r_s1r      <= '0;
            r_s2r      <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_cnt      <= '0;
            r_iss_vld  <= 1'b0;
            r_iss_mop  <= '0;
            r_iss_pc   <= '0;
            r_iss_pred <= 1'b0;
            r_iss_off  <= '0;
            r_iss_rd   <= '0;
            r_iss_s1d  <= '0;
            r_iss_s2d  <= '0;
        end else if (bus.Flush) begin
            r_vld     <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_cnt     <= '0;
            r_iss_vld <= 1'b0;
        end else begin
            r_iss_vld <= w_iss;
            r_s1r     <= r_s1r | w_wake1;
            r_s2r     <= r_s2r | w_wake2;
            if (w_iss) begin
                r_vld[r_head] <= 1'b0;
                r_iss_mop     <= r_mop[r_head];
                r_iss_pc      <= r_pc[r_head];
                r_iss_pred    <= r_pred[r_head];
                r_iss_off     <= r_off[r_head];
                r_iss_rd      <= r_rd[r_head];
                r_iss_s1d     <= r_s1d[r_head];
                r_iss_s2d     <= r_s2d[r_head];
                r_head        <= r_head + 1'b1;
            end
            // The tail slot is never valid while not full, so these writes cannot collide with issue.
            if (w_enq) begin
                r_vld[r_tail] <= 1'b1;
                r_s1r[r_tail] <= w_in1_rdy;
                r_s2r[r_tail] <= w_in2_rdy;
                r_tail        <= r_tail + 1'b1;
            end
            r_cnt <= r_cnt + CW'(w_enq) - CW'(w_iss);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wake1[i]) r_s1d[i] <= bus.WbData;
            if (w_wake2[i]) r_s2d[i] <= bus.WbData;
        end
        if (w_enq) begin
            r_mop[r_tail]  <= bus.InMicOp;
            r_pc[r_tail]   <= bus.InInstAddr;
            r_pred[r_tail] <= bus.InPredict;
            r_off[r_tail]  <= bus.InJumpOffset;
            r_rd[r_tail]   <= bus.InRdAddr;
            r_s1a[r_tail]  <= bus.InSrc1Addr;
            r_s2a[r_tail]  <= bus.InSrc2Addr;
            r_s1d[r_tail]  <= bus.InSrc1Rdy ? bus.InSrc1Data : bus.WbData;
            r_s2d[r_tail]  <= bus.InSrc2Rdy ? bus.InSrc2Data : bus.WbData;
        end
    end

    assign bus.IssValid      = r_iss_vld;
    assign bus.IssMicOp      = r_iss_mop;
    assign bus.IssInstAddr   = r_iss_pc;
    assign bus.IssPredict    = r_iss_pred;
    assign bus.IssJumpOffset = r_iss_off;
    assign bus.IssRdAddr     = r_iss_rd;
    assign bus.IssSrc1Data   = r_iss_s1d;
    assign bus.IssSrc2Data   = r_iss_s2d;
    assign bus.Count         = r_cnt;
endmodule

// File: tb/tb_fp_issue_queue.sv
// Scoreboard bench for fp_issue_queue: a queue-based reference model predicts
// every issued op, occupancy and InReady; a negedge monitor compares.
module tb_fp_issue_queue;
    localparam int DEPTH = 8;

    logic clk, rst;
    int   checks = 0;
    int   failures = 0;

    fp_issue_queue_if #(.DEPTH(DEPTH), .MOP_W(8), .AW(32), .RAW(5), .DW(64)) bus ();

    fp_issue_queue #(.DEPTH(DEPTH), .MOP_W(8), .AW(32), .RAW(5), .DW(64)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mop;
        logic [31:0] pc;
        logic        pred;
        logic [31:0] off;
        logic [4:0]  rd;
        logic [4:0]  a1, a2;
        logic        r1, r2;
        logic [63:0] d1, d2;
    } op_t;

    op_t mq[$];   // ops held by the queue, oldest first
    op_t exq[$];  // ops expected on the issue port next cycle

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: one step per clock edge, straight from the queue rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exq.delete();
        end else if (bus.Flush) begin
            mq.delete();
        end else begin
            int  n_before;
            op_t e;
            n_before = mq.size();
            if (mq.size() > 0 && mq[0].r1 && mq[0].r2) begin
                exq.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (bus.WbValid) begin
                for (int i = 0; i < mq.size(); i++) begin
                    e = mq[i];
                    if (!e.r1 && e.a1 == bus.WbAddr) begin e.r1 = 1'b1; e.d1 = bus.WbData; end
                    if (!e.r2 && e.a2 == bus.WbAddr) begin e.r2 = 1'b1; e.d2 = bus.WbData; end
                    mq[i] = e;
                end
            end
            if (bus.InValid && n_before < DEPTH) begin
                e.mop  = bus.InMicOp;
                e.pc   = bus.InInstAddr;
                e.pred = bus.InPredict;
                e.off  = bus.InJumpOffset;
                e.rd   = bus.InRdAddr;
                e.a1   = bus.InSrc1Addr;
                e.a2   = bus.InSrc2Addr;
                e.r1   = bus.InSrc1Rdy;
                e.r2   = bus.InSrc2Rdy;
                e.d1   = bus.InSrc1Data;
                e.d2   = bus.InSrc2Data;
                if (!e.r1 && bus.WbValid && bus.WbAddr == e.a1) begin e.r1 = 1'b1; e.d1 = bus.WbData; end
                if (!e.r2 && bus.WbValid && bus.WbAddr == e.a2) begin e.r2 = 1'b1; e.d2 = bus.WbData; end
                mq.push_back(e);
            end
        end
    end

    // Monitor: compares the DUT with the model away from the active edge.
    always @(negedge clk) begin
        op_t x;
        chk("count", 64'(bus.Count), 64'(mq.size()));
        chk("in_ready", 64'(bus.InReady), 64'(mq.size() < DEPTH));
        chk("iss_valid", 64'(bus.IssValid), 64'(exq.size() != 0));
        if (exq.size() != 0) begin
            x = exq.pop_front();
            if (bus.IssValid) begin
                chk("iss_micop", 64'(bus.IssMicOp), 64'(x.mop));
                chk("iss_pc", 64'(bus.IssInstAddr), 64'(x.pc));
                chk("iss_pred", 64'(bus.IssPredict), 64'(x.pred));
                chk("iss_offset", 64'(bus.IssJumpOffset), 64'(x.off));
                chk("iss_rd", 64'(bus.IssRdAddr), 64'(x.rd));
                chk("iss_src1", bus.IssSrc1Data, x.d1);
                chk("iss_src2", bus.IssSrc2Data, x.d2);
            end
        end
    end

    task automatic idle();
        bus.InValid = 1'b0;
        bus.WbValid = 1'b0;
        bus.Flush   = 1'b0;
    endtask

    task automatic set_enq(input logic [7:0] mop, input logic r1, input logic [4:0] a1,
                           input logic [63:0] d1, input logic r2, input logic [4:0] a2,
                           input logic [63:0] d2);
        bus.InValid      = 1'b1;
        bus.InMicOp      = mop;
        bus.InInstAddr   = $urandom;
        bus.InPredict    = 1'($urandom);
        bus.InJumpOffset = $urandom;
        bus.InRdAddr     = 5'($urandom);
        bus.InSrc1Rdy    = r1;
        bus.InSrc1Addr   = a1;
        bus.InSrc1Data   = d1;
        bus.InSrc2Rdy    = r2;
        bus.InSrc2Addr   = a2;
        bus.InSrc2Data   = d2;
    endtask

    task automatic set_wb(input logic [4:0] a, input logic [63:0] d);
        bus.WbValid = 1'b1;
        bus.WbAddr  = a;
        bus.WbData  = d;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idles(input int n);
        for (int k = 0; k < n; k++) begin idle(); tick(); end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        bus.InMicOp = '0; bus.InInstAddr = '0; bus.InPredict = 1'b0; bus.InJumpOffset = '0;
        bus.InRdAddr = '0; bus.InSrc1Addr = '0; bus.InSrc2Addr = '0; bus.InSrc1Rdy = 1'b0;
        bus.InSrc2Rdy = 1'b0; bus.InSrc1Data = '0; bus.InSrc2Data = '0;
        bus.WbAddr = '0; bus.WbData = '0;
        #12;
        chk("rst_iss_valid", 64'(bus.IssValid), 64'd0);
        chk("rst_iss_micop", 64'(bus.IssMicOp), 64'd0);
        chk("rst_iss_src1", bus.IssSrc1Data, 64'd0);
        chk("rst_count", 64'(bus.Count), 64'd0);
        chk("rst_in_ready", 64'(bus.InReady), 64'd1);
        tick();
        rst = 1'b0;
        idles(2);

        // Ready op: issues two cycles after dispatch.
        set_enq(8'h12, 1'b1, 5'd1, 64'h3F800000, 1'b1, 5'd2, 64'h40000000); tick();
        idles(4);

        // Pending src2 on r7; r6 writeback must not wake it.
        set_enq(8'h21, 1'b1, 5'd1, 64'h11, 1'b0, 5'd7, 64'h0); tick();
        idle(); set_wb(5'd6, 64'hDEAD); tick();
        idles(2);
        idle(); set_wb(5'd7, 64'h40400000); tick();
        idles(4);

        // Same-cycle dispatch and writeback of src1.
        idle();
        set_enq(8'h33, 1'b0, 5'd3, 64'h0, 1'b1, 5'd4, 64'h55);
        set_wb(5'd3, 64'hAA); tick();
        idles(4);

        // Fill with a blocked head, try a ninth op, then drain across the wrap.
        for (int k = 0; k < DEPTH; k++) begin
            idle();
            set_enq(8'(8'h40 + k), (k != 0), 5'd10, rnd64(), 1'b1, 5'd11, rnd64());
            tick();
        end
        chk("full_in_ready", 64'(bus.InReady), 64'd0);
        chk("full_count", 64'(bus.Count), 64'(DEPTH));
        idle(); set_enq(8'h4F, 1'b1, 5'd1, rnd64(), 1'b1, 5'd1, rnd64()); tick();
        idle(); set_wb(5'd10, 64'hBEEF); tick();
        idles(4);
        for (int k = 0; k < 3; k++) begin
            idle(); set_enq(8'(8'h50 + k), 1'b1, 5'd1, rnd64(), 1'b1, 5'd2, rnd64()); tick();
        end
        idles(12);

        // In-order blocking: ready younger op waits behind the head.
        idle(); set_enq(8'h61, 1'b0, 5'd4, 64'h0, 1'b1, 5'd5, 64'h66); tick();
        idle(); set_enq(8'h62, 1'b1, 5'd5, 64'h77, 1'b1, 5'd5, 64'h88); tick();
        idles(3);
        idle(); set_wb(5'd4, 64'h99); tick();
        idles(5);

        // Flush while the head is issuable, with a competing enqueue.
        for (int k = 0; k < 5; k++) begin
            idle(); set_enq(8'(8'h70 + k), (k != 0), 5'd9, rnd64(), 1'b1, 5'd8, rnd64()); tick();
        end
        idle(); set_wb(5'd9, 64'h1234); tick();
        idle(); set_enq(8'h7F, 1'b1, 5'd1, rnd64(), 1'b1, 5'd1, rnd64()); bus.Flush = 1'b1; tick();
        chk("flush_count", 64'(bus.Count), 64'd0);
        chk("flush_iss_valid", 64'(bus.IssValid), 64'd0);
        idle(); set_enq(8'h80, 1'b1, 5'd1, rnd64(), 1'b1, 5'd1, rnd64()); tick();
        idles(4);

        // Randomised traffic over a small register space.
        for (int c = 0; c < 1500; c++) begin
            idle();
            if ($urandom_range(3, 0) != 0)
                set_enq(8'($urandom), ($urandom_range(2, 0) != 0), 5'($urandom_range(7, 0)), rnd64(),
                        ($urandom_range(2, 0) != 0), 5'($urandom_range(7, 0)), rnd64());
            if ($urandom_range(2, 0) == 0) set_wb(5'($urandom_range(7, 0)), rnd64());
            if ($urandom_range(63, 0) == 0) bus.Flush = 1'b1;
            tick();
        end

        // Async reset mid-stream with entries held and a recent issue on the port.
        idle(); set_enq(8'hC1, 1'b1, 5'd1, rnd64(), 1'b1, 5'd1, rnd64()); tick();
        for (int k = 0; k < 4; k++) begin
            idle(); set_enq(8'(8'hD0 + k), 1'b0, 5'd12, rnd64(), 1'b1, 5'd1, rnd64()); tick();
        end
        idle();
        #2 rst = 1'b1;
        #1;
        chk("arst_iss_valid", 64'(bus.IssValid), 64'd0);
        chk("arst_iss_micop", 64'(bus.IssMicOp), 64'd0);
        chk("arst_iss_pc", 64'(bus.IssInstAddr), 64'd0);
        chk("arst_iss_src1", bus.IssSrc1Data, 64'd0);
        chk("arst_iss_src2", bus.IssSrc2Data, 64'd0);
        chk("arst_count", 64'(bus.Count), 64'd0);
        tick(); tick();
        rst = 1'b0;
        idle(); set_wb(5'd12, 64'h5A5A); tick();
        idle(); set_enq(8'hE1, 1'b1, 5'd2, rnd64(), 1'b1, 5'd3, rnd64()); tick();
        idles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_issue_queue.md
# fp_issue_queue

In-order issue queue feeding the floating-point ALU. It accepts decoded FP micro-ops from rename/dispatch and holds them with source operand data. It snoops the FALU writeback bus to capture operands that were still in flight at dispatch. The oldest entry issues to the FALU once both sources are ready, and a FALU-reported redirect flushes the queue.

## Interface
Parameters:
- DEPTH, 8, queue entries; power of two, ≥2
- MOP_W, 8, micro-op code width
- AW, 32, instruction address width
- RAW, 5, architectural FP register address width
- DW, 64, operand/result data width

Ports:
- Clk  in  1  clock, all state on rising edge
- Rest  in  1  reset, asynchronous, active-high
- InValid  in  1  dispatch offers an op
- InReady  out  1  queue can accept (count < DEPTH)
- InMicOp  in  MOP_W  micro-op code
- InInstAddr  in  AW  instruction PC
- InPredict  in  1  branch-predict bit
- InJumpOffset  in  32  branch offset
- InRdAddr  in  RAW  destination register
- InSrc1Addr, InSrc2Addr  in  RAW  source register addresses
- InSrc1Rdy, InSrc2Rdy  in  1  source data valid at dispatch
- InSrc1Data, InSrc2Data  in  DW  source data (meaningful only when ready)
- WbValid  in  1  FALU result valid (FALU OutDataAble)
- WbAddr  in  RAW  FALU result register (OutRdAddr)
- WbData  in  DW  FALU result data (OutRddata)
- Flush  in  1  redirect (FALU JumpFaluvalue)
- IssValid  out  1  one-cycle issue strobe to FALU
- IssMicOp, IssInstAddr, IssPredict, IssJumpOffset, IssRdAddr  out  matching widths  issued op fields
- IssSrc1Data, IssSrc2Data  out  DW  FArchRegister1/2
- Count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer: head/tail pointers, $clog2(DEPTH) bits each, wrap modulo DEPTH; Count tracked separately, so full = (Count==DEPTH) and empty = (Count==0).
- Enqueue when InValid & InReady. Write all fields at tail, set valid, and latch per-source ready/data. Advance tail.
- Wakeup: for every valid entry and every source not ready whose address == WbAddr while WbValid is high, capture WbData and set ready. The comparison runs across all entries in parallel.
- Wakeup during enqueue: if the incoming source is not ready and WbValid & WbAddr==InSrcXAddr in the same cycle, the entry is written ready with WbData.
- Issue: head issues when valid & src1 ready & src2 ready, using registered ready bits. A wakeup that targets the head takes effect the next cycle; there is no same-cycle bypass. Issue copies head fields into output registers, pulses IssValid, clears the head entry's valid bit and advances head.
- Strictly in order: younger ready entries never bypass the head.
- Enqueue and issue in the same cycle are allowed. Count = Count + enq − iss.
- InReady is combinational from Count only (Count < DEPTH). A full queue does not accept even while issuing in the same cycle.
- Flush has priority over enqueue, wakeup and issue. It clears all valid bits, sets head = tail = 0 and Count = 0, and forces IssValid low next cycle. An issue registered in the flush cycle is suppressed.
- Reset (async) has the same effect as flush. All Iss* data outputs go to 0 and IssValid to 0. Reset mid-operation discards every entry.

## Timing
- Reset values: IssValid 0, all Iss* fields 0, Count 0, InReady 1.
- Enqueue at cycle N with both sources ready → IssValid high in cycle N+2 if the queue was empty (minimum latency 2).
- Wakeup at cycle N for a head source → IssValid in cycle N+2.
- Throughput: 1 issue per cycle when consecutive entries are ready.
- IssValid high for exactly one cycle per issued op. Output fields hold their last values when IssValid is low.
- Flush in cycle N: Count reads 0 in N+1, InReady 1 in N+1, and an enqueue is accepted from N+1.

## Test plan
- Ready op: enqueue MicOp=0x12, Src1Data=0x3F800000, Src2Data=0x40000000, both ready → IssValid at +2 cycles with matching data and RdAddr; Count 1→0.
- Pending operand: enqueue with Src2Rdy=0, Src2Addr=7; later WbValid, WbAddr=7, WbData=0x40400000 → issue two cycles after wakeup with IssSrc2Data=0x40400000; WbAddr=6 does not wake it.
- Same-cycle dispatch/wakeup: InSrc1Rdy=0, InSrc1Addr=3 while WbAddr=3, WbData=0xAA → entry issues with IssSrc1Data=0xAA and no further wakeup needed.
- Full/wrap: enqueue 8 ops while the head is blocked → InReady=0 at Count=8. Wake the head, drain 3, enqueue 3 → tail wraps, and issue order equals enqueue order across the wrap.
- In-order blocking: head waiting, entry 1 ready → no IssValid until the head wakes; then head issues, then entry 1 the next cycle.
- Flush/reset: with 5 entries, Flush while the head is issuable → IssValid low next cycle, Count=0. Asserting Rest asynchronously mid-stream → outputs zero immediately and the queue is empty after release.
